// File: rtl/fifo_fwft_pkg.sv
// Shared sizing helpers for the first-word-fall-through FIFO and its RAM.
package fifo_fwft_pkg;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   // One extra wrap bit distinguishes a full RAM from an empty one.
   function automatic int ptr_width_of(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-clock simple dual-port RAM with registered read; maps onto block RAM.
module fifo_ram
   import fifo_fwft_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     re,
   input  logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   localparam int DEPTH = depth_of(ADDRESS_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_fwft.sv
// Show-ahead FIFO: RAM, a one-word read stage and an output register, with level and sticky error flags.
module fifo_fwft
   import fifo_fwft_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDRESS_WIDTH      = 8,
   parameter int ALMOST_FULL_LEVEL  = depth_of(ADDRESS_WIDTH) - 4,
   parameter int ALMOST_EMPTY_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     we,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     re,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     valid,
   output logic                     almost_empty,
   output logic [ADDRESS_WIDTH:0]   level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int DEPTH     = depth_of(ADDRESS_WIDTH);
   localparam int PTR_WIDTH = ptr_width_of(ADDRESS_WIDTH);

   localparam logic [PTR_WIDTH-1:0] LVL_FULL = PTR_WIDTH'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] LVL_AF   = PTR_WIDTH'(ALMOST_FULL_LEVEL);
   localparam logic [PTR_WIDTH-1:0] LVL_AE   = PTR_WIDTH'(ALMOST_EMPTY_LEVEL);

   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]  level_q, level_d;
   logic                  mid_vld_q, mid_vld_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  push, pop, out_load, ram_rd;
   logic [DATA_WIDTH-1:0] ram_rdata;

   fifo_ram #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr_q[ADDRESS_WIDTH-1:0]),
      .wdata(data_in),
      .re   (ram_rd),
      .raddr(rd_ptr_q[ADDRESS_WIDTH-1:0]),
      .rdata(ram_rdata)
   );

   assign full = (level_q == LVL_FULL);

   // The RAM read register is the middle stage; it is only reloaded once its word has moved on.
   always_comb begin
      push     = ~clear & we & ~full;
      pop      = ~clear & re & valid_q;
      out_load = ~clear & mid_vld_q & (~valid_q | pop);
      ram_rd   = ~clear & (wr_ptr_q != rd_ptr_q) & (~mid_vld_q | out_load);

      wr_ptr_d    = wr_ptr_q + PTR_WIDTH'(push);
      rd_ptr_d    = rd_ptr_q + PTR_WIDTH'(ram_rd);
      level_d     = level_q + PTR_WIDTH'(push) - PTR_WIDTH'(pop);
      mid_vld_d   = ram_rd | (mid_vld_q & ~out_load);
      valid_d     = out_load | (valid_q & ~pop);
      data_out_d  = out_load ? ram_rdata : data_out_q;
      overflow_d  = overflow_q | (we & full);
      underflow_d = underflow_q | (re & ~valid_q);

      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         mid_vld_d   = 1'b0;
         valid_d     = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         mid_vld_q   <= 1'b0;
         valid_q     <= 1'b0;
         data_out_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         mid_vld_q   <= mid_vld_d;
         valid_q     <= valid_d;
         data_out_q  <= data_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);
   assign level        = level_q;
   assign valid        = valid_q;
   assign data_out     = data_out_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: doc/fifo_fwft.md
# fifo_fwft

Parametrised first-word-fall-through FIFO for byte/word streams between producer and consumer logic in the same clock domain. It succeeds the plain `fifo` with:
- full-capacity storage of 2**ADDRESS_WIDTH words,
- a show-ahead output with an explicit valid,
- an occupancy count with programmable almost-full/almost-empty thresholds,
- sticky overflow/underflow error flags, synchronous flush and asynchronous active-low reset.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDRESS_WIDTH, 8, log2 of capacity; DEPTH = 2**ADDRESS_WIDTH words
- ALMOST_FULL_LEVEL, DEPTH-4, almost_full asserted when level >= this
- ALMOST_EMPTY_LEVEL, 4, almost_empty asserted when level <= this

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush, priority over we/re
- we  in  1  write request
- data_in  in  DATA_WIDTH  write data
- full  out  1  level == DEPTH
- almost_full  out  1  level >= ALMOST_FULL_LEVEL
- re  in  1  pop request; acts only when valid
- data_out  out  DATA_WIDTH  head word, meaningful while valid
- valid  out  1  data_out holds the oldest unread word
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL
- level  out  ADDRESS_WIDTH+1  accepted words not yet popped
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while not valid

## Operation
- Reset (rst_n low, any time, including mid-transfer) clears everything immediately:
  - pointers, level, full, almost_full, valid, data_out, overflow and underflow go to 0.
  - almost_empty goes to 1.
- Write accepted at an edge when we & ~full, with full sampled before the edge. The word is stored and level increments.
- Pop at an edge when re & valid. The head is consumed and level decrements. The next word, if any, is presented without a further re.
- we & re on the same edge when both are accepted: level unchanged, both take effect.
- The full check uses the pre-edge level. A write while full is dropped even if a pop occurs on the same edge, and it sets overflow.
- re while ~valid sets underflow and leaves state unchanged.
- clear at an edge:
  - pointers, level, valid, overflow and underflow go to 0.
  - almost_empty goes to 1.
  - concurrent we/re are ignored.
- Pointers are ADDRESS_WIDTH+1 bits (wrap bit) and wrap modulo 2*DEPTH. The RAM index is the low ADDRESS_WIDTH bits.
- The output register counts toward level. Total capacity is exactly DEPTH: the RAM plus output stage never hold more than DEPTH words.
- data_out holds its value while ~valid. No requirement is placed on its contents in that state.

## Timing
- full, almost_full, almost_empty and level are registered or decoded from registered level only. They update on the edge of the accepted operation. Example: after a write into an empty FIFO, level = 1 one edge later.
- Write-to-valid latency into an empty FIFO is 2 edges: the RAM write edge, then the output-register load edge. A word written at edge t is valid after edge t+2.
- Steady-state throughput is one write and one pop per cycle, with no bubbles while level >= 2.
- A pop with level == 1 drops valid after that edge.
- RAM is inferable as single-clock simple dual-port, registered read (iCE40 EBR).

## Structure
- A shared include holds localparams DEPTH and PTR_WIDTH = ADDRESS_WIDTH+1.
- One sub-module, `fifo_ram`: simple dual-port RAM with a registered read. It has no reset.
- Top level holds the pointers, level counter, prefetch/valid logic and flags.

## Test plan
- Reset mid-stream: write 3 words, assert rst_n low between edges → all outputs immediately at reset values. After release, level = 0 and valid = 0.
- Fill/drain with ADDRESS_WIDTH=4: write 0x00..0x0F → full = 1, level = 16. A 17th write → overflow = 1, level stays 16. Pop 16 → data 0x00..0x0F in order, then valid = 0.
- Latency: write 0xA5 into empty at edge t → valid = 1 with data_out = 0xA5 after edge t+2.
- Simultaneous traffic: hold level = 5, then drive we & re for 100 cycles → level stays 5 and the output sequence is intact across pointer wrap.
- Thresholds: with ALMOST_FULL_LEVEL = 12 and ALMOST_EMPTY_LEVEL = 4, step level 0→16→0 → almost_empty toggles at 4↔5 and almost_full at 11↔12.
- Errors and clear: re on empty → underflow = 1. Then clear with we asserted → level = 0, flags = 0, and the write is ignored.
